// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//   Fetch-side initiator for a combinational instruction ROM. Owns the PC,
//   drives ROM chip-enable/address, captures the returned word and queues
//   {pc, inst} pairs in a small FIFO toward decode (valid/ready handshake).
//   Handles stall, branch redirect (with FIFO flush) and misaligned-target halt.
//
// Ports
//   clk              in   1   system clock, rising edge
//   rst              in   1   synchronous reset, active-high
//   stall_i          in   1   hold PC, no new fetch
//   branch_flag_i    in   1   redirect pulse
//   branch_target_i  in   32  redirect address
//   rom_ce_o         out  1   ROM chip enable
//   rom_addr_o       out  32  ROM byte address (= PC)
//   rom_inst_i       in   32  ROM data, valid same cycle
//   if_valid_o       out  1   FIFO head valid
//   if_ready_i       in   1   decode accepts head
//   if_pc_o          out  32  head PC (0 when empty)
//   if_inst_o        out  32  head instruction (0 when empty)
//   misalign_o       out  1   sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        misalign_o
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic               r_rom_ce;
    logic               r_misalign;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [31:0]        r_mem_pc   [BUF_DEPTH];
    logic [31:0]        r_mem_inst [BUF_DEPTH];

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_flush;
    logic [CNT_W-1:0]   w_push_ext;
    logic [CNT_W-1:0]   w_pop_ext;

    always_comb begin
        w_valid    = (r_count != '0);
        w_pop      = w_valid & if_ready_i;
        w_flush    = (r_state == StRun) & branch_flag_i;
        // A full FIFO can still accept a word when the head leaves this cycle.
        w_push     = (r_state == StRun) & r_rom_ce & ~stall_i & ~branch_flag_i
                     & ((r_count < DEPTH_C) | w_pop);
        w_push_ext = {{(CNT_W-1){1'b0}}, w_push};
        w_pop_ext  = {{(CNT_W-1){1'b0}}, w_pop};
    end

    // Control state, PC and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_rom_ce   <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_state  <= StRun;
                    r_rom_ce <= 1'b1;
                end
                StRun: begin
                    if (branch_flag_i && (branch_target_i[1:0] != 2'b00)) begin
                        r_state    <= StHalt;
                        r_rom_ce   <= 1'b0;
                        r_misalign <= 1'b1;
                    end
                end
                StHalt: begin
                    r_rom_ce <= 1'b0;
                end
                default: begin
                    r_state  <= StIdle;
                    r_rom_ce <= 1'b0;
                end
            endcase

            if (w_flush) begin
                // Redirect discards every queued entry, including one popped now.
                r_pc     <= branch_target_i;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_pc     <= r_pc + 32'd4;
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + w_push_ext - w_pop_ext;
            end
        end
    end

    // Storage needs no reset: entries are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_pc;
            r_mem_inst[r_wr_ptr] <= rom_inst_i;
        end
    end

    always_comb begin
        rom_ce_o   = r_rom_ce;
        rom_addr_o = r_pc;
        misalign_o = r_misalign;
        if_valid_o = w_valid;
        if_pc_o    = w_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;
        if_inst_o  = w_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch. Directed scenarios followed by random
//   stall/ready/branch/reset traffic, compared each cycle against a queue-based
//   reference model. A second instance with RESET_PC near the top of the
//   address space checks PC wrap after each reset until the first redirect.
// ----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int BUF_DEPTH = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        if_ready_i;

    logic        rom_ce_o,   rom_ce_w;
    logic [31:0] rom_addr_o, rom_addr_w;
    logic [31:0] rom_inst_i, rom_inst_w;
    logic        if_valid_o, if_valid_w;
    logic [31:0] if_pc_o,    if_pc_w;
    logic [31:0] if_inst_o,  if_inst_w;
    logic        misalign_o, misalign_w;

    int n_checks = 0;
    int n_errors = 0;

    // ROM: word[i] = i
    assign rom_inst_i = {2'b00, rom_addr_o[31:2]};
    assign rom_inst_w = {2'b00, rom_addr_w[31:2]};

    inst_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .if_valid_o      (if_valid_o),
        .if_ready_i      (if_ready_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .misalign_o      (misalign_o)
    );

    inst_fetch #(
        .RESET_PC  (WRAP_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut_w (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_w),
        .rom_addr_o      (rom_addr_w),
        .rom_inst_i      (rom_inst_w),
        .if_valid_o      (if_valid_w),
        .if_ready_i      (if_ready_i),
        .if_pc_o         (if_pc_w),
        .if_inst_o       (if_inst_w),
        .misalign_o      (misalign_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = idle, 1 = fetching, 2 = halted.
    int          m_mode;
    bit          m_ce;
    bit          m_mis;
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_track_w;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_ce      = 1'b0;
        m_mis     = 1'b0;
        m_pc      = 32'h0;
        m_track_w = 1'b1;
        m_q.delete();
    endtask

    task automatic model_step(input bit r, input bit st, input bit br,
                              input logic [31:0] tgt, input bit rdy);
        bit pop;
        if (r) begin
            model_reset();
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_ce   = 1'b1;
        end else if (m_mode == 1) begin
            pop = (m_q.size() != 0) && rdy;
            if (br) begin
                m_q.delete();
                m_pc      = tgt;
                m_track_w = 1'b0;
                if (tgt[1:0] != 2'b00) begin
                    m_mis  = 1'b1;
                    m_mode = 2;
                    m_ce   = 1'b0;
                end
            end else begin
                if (pop) void'(m_q.pop_front());
                if (!st && m_q.size() < BUF_DEPTH) begin
                    m_q.push_back({m_pc, rom_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end else begin
            if ((m_q.size() != 0) && rdy) void'(m_q.pop_front());
        end
    endtask

    task automatic check_outputs();
        logic        vld;
        logic [31:0] hpc;
        logic [31:0] hinst;
        logic [31:0] wpc;
        vld   = (m_q.size() != 0);
        hpc   = vld ? m_q[0][63:32] : 32'h0;
        hinst = vld ? m_q[0][31:0]  : 32'h0;
        check_eq("rom_ce",   {31'b0, rom_ce_o},   {31'b0, m_ce});
        check_eq("rom_addr", rom_addr_o,          m_pc);
        check_eq("valid",    {31'b0, if_valid_o}, {31'b0, vld});
        check_eq("head_pc",  if_pc_o,             hpc);
        check_eq("head_inst", if_inst_o,          hinst);
        check_eq("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
        if (m_track_w) begin
            // Until the first redirect the second instance runs 8 bytes behind.
            wpc = vld ? hpc + WRAP_PC : 32'h0;
            check_eq("w_rom_addr", rom_addr_w, m_pc + WRAP_PC);
            check_eq("w_head_pc",  if_pc_w,    wpc);
            check_eq("w_head_inst", if_inst_w, vld ? rom_word(wpc) : 32'h0);
        end
    endtask

    task automatic cycle(input bit r, input bit st, input bit br,
                         input logic [31:0] tgt, input bit rdy);
        rst             = r;
        stall_i         = st;
        branch_flag_i   = br;
        branch_target_i = tgt;
        if_ready_i      = rdy;
        check_outputs();
        model_step(r, st, br, tgt, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tgt;
        bit          r, st, br, rdy;

        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        if_ready_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // T1: reset then free-running fetch
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // T2: back-pressure from decode, then release
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // T3: queue two entries, then stall while draining
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // T4: redirect while full and stalled
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // T5: misaligned redirect halts; later redirect ignored; reset clears
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0042, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(59) == 0);
            st  = ($urandom_range(3) == 0);
            br  = ($urandom_range(15) == 0);
            rdy = ($urandom_range(2) != 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            cycle(r, st, br, tgt, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
